bht_local: RTL

- Next-generation set-associative branch history table for the fetch front end.
- Each entry holds a tag, a branch target, a BH_BITS-wide local history register (BHR), and 2^BH_BITS saturating counters of COUNTER_BITS each.
- The predict port is looked up combinationally from the F1 pc. The update port is driven from EXE and retired through a one-stage registered read-modify-write pipeline.
- Adds tree-PLRU for any power-of-2 associativity, a generic counter width, and an explicit init-sweep FSM with a ready flag.

---
 rtl/bht_pkg.sv | 45 ++++
 rtl/bht_local_plru.sv | 28 ++
 rtl/bht_local.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/bht_pkg.sv
// bht_pkg: shared sizing, types and helpers for the local-history branch history table.
package bht_pkg;
    localparam int ASSOCIATIVITY = 4;
    localparam int SET_NUM       = 16;
    localparam int BH_BITS       = 2;
    localparam int COUNTER_BITS  = 2;
    localparam int TAG_BITS      = 16;
    localparam int INDEX_BITS    = $clog2(SET_NUM);
    localparam int WAY_BITS      = $clog2(ASSOCIATIVITY);
    localparam int NUM_CNT       = 1 << BH_BITS;

    typedef logic [INDEX_BITS-1:0]    index_t;
    typedef logic [TAG_BITS-1:0]      tag_t;
    typedef logic [BH_BITS-1:0]       bhr_t;
    typedef logic [COUNTER_BITS-1:0]  counter_t;
    typedef logic [ASSOCIATIVITY-2:0] plru_t;
    typedef logic [WAY_BITS-1:0]      way_t;

    typedef struct packed {
        logic valid;
        tag_t tag;
    } meta_t;

    typedef struct packed {
        logic [31:0]                target;
        bhr_t                       bhr;
        counter_t [NUM_CNT-1:0]     counter;
    } entry_t;

    function automatic index_t get_index(logic [31:0] pc);
        return pc[2+INDEX_BITS-1:2];
    endfunction

    function automatic tag_t get_tag(logic [31:0] pc);
        return pc[2+INDEX_BITS+TAG_BITS-1:2+INDEX_BITS];
    endfunction

    function automatic counter_t sat_inc(counter_t c);
        return (&c) ? c : c + 1'b1;
    endfunction

    function automatic counter_t sat_dec(counter_t c);
        return (|c) ? c - 1'b1 : c;
    endfunction
endpackage

// File: rtl/bht_local_plru.sv
// plru_tree: tree pseudo-LRU for one set; node n has children 2n+1 (lower half) and 2n+2.
module plru_tree #(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0]         tree,
    input  logic [$clog2(WAYS)-1:0] touch,
    output logic [WAYS-2:0]         next_tree,
    output logic [$clog2(WAYS)-1:0] victim
);
    localparam int LVL = $clog2(WAYS);

    // A node bit of 0 steers the victim into the lower half; a touch points it at the other half.
    always_comb begin
        next_tree = tree;
        for (int l = 0; l < LVL; l++)
            for (int p = 0; p < (1 << l); p++)
                if (int'(touch >> (LVL - l)) == p) next_tree[(1 << l) - 1 + p] = ~touch[LVL-1-l];
    end

    always_comb begin
        logic [LVL-1:0] v;
        v = '0;
        for (int l = 0; l < LVL; l++)
            for (int p = 0; p < (1 << l); p++)
                if (int'(v >> (LVL - l)) == p) v[LVL-1-l] = tree[(1 << l) - 1 + p];
        victim = v;
    end
endmodule

// File: rtl/bht_local.sv
// bht_local: set-associative local-history branch predictor with tree-PLRU replacement,
// an init sweep after reset and a one-stage registered read-modify-write update path.
module bht_local
    import bht_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        pred_valid,
    input  logic [31:0] pred_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic        ready
);
    typedef enum logic {INIT, RUN} state_t;

    state_t state, state_next;
    index_t sweep_idx;

    meta_t  meta  [SET_NUM][ASSOCIATIVITY];
    entry_t entry [SET_NUM][ASSOCIATIVITY];
    plru_t  plru  [SET_NUM];

    logic        u_valid, u_taken;
    index_t      u_idx;
    tag_t        u_tag;
    logic [31:0] u_target;

    index_t p_idx;
    tag_t   p_tag;
    logic   p_hit;
    way_t   p_way;
    entry_t p_ent;
    plru_t  p_plru_next;

    logic   u_hit, u_inv, u_write;
    way_t   u_way, u_inv_way, u_plru_victim, u_wr_way;
    entry_t u_old, u_new;
    plru_t  u_plru_next;

    assign ready = state == RUN;

    always_comb begin
        state_next = state;
        if (state == INIT && sweep_idx == index_t'(SET_NUM - 1)) state_next = RUN;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= INIT;
            sweep_idx <= '0;
            u_valid   <= 1'b0;
            u_taken   <= 1'b0;
            u_idx     <= '0;
            u_tag     <= '0;
            u_target  <= '0;
        end else begin
            state     <= state_next;
            sweep_idx <= state == INIT ? sweep_idx + 1'b1 : sweep_idx;
            u_valid   <= upd_valid && state == RUN;
            u_taken   <= upd_taken;
            u_idx     <= get_index(upd_pc);
            u_tag     <= get_tag(upd_pc);
            u_target  <= upd_target;
        end
    end

    assign p_idx = get_index(pred_pc);
    assign p_tag = get_tag(pred_pc);

    always_comb begin
        p_hit = 1'b0;
        p_way = '0;
        for (int w = 0; w < ASSOCIATIVITY; w++)
            if (meta[p_idx][w].valid && meta[p_idx][w].tag == p_tag) begin
                p_hit = 1'b1;
                p_way = way_t'(w);
            end
    end

    assign p_ent       = entry[p_idx][p_way];
    assign pred_hit    = ready && p_hit;
    assign pred_taken  = pred_hit && p_ent.counter[p_ent.bhr][COUNTER_BITS-1];
    assign pred_target = pred_hit ? p_ent.target : '0;

    // Descending scan leaves the lowest-index invalid way as the allocation candidate.
    always_comb begin
        u_hit     = 1'b0;
        u_way     = '0;
        u_inv     = 1'b0;
        u_inv_way = '0;
        for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
            if (meta[u_idx][w].valid && meta[u_idx][w].tag == u_tag) begin
                u_hit = 1'b1;
                u_way = way_t'(w);
            end
            if (!meta[u_idx][w].valid) begin
                u_inv     = 1'b1;
                u_inv_way = way_t'(w);
            end
        end
    end

    assign u_wr_way = u_hit ? u_way : u_inv ? u_inv_way : u_plru_victim;
    assign u_write  = u_valid && (u_hit || u_taken);
    assign u_old    = entry[u_idx][u_way];

    always_comb begin
        u_new = u_old;
        if (u_hit) begin
            u_new.counter[u_old.bhr] = u_taken ? sat_inc(u_old.counter[u_old.bhr])
                                               : sat_dec(u_old.counter[u_old.bhr]);
            u_new.bhr    = bhr_t'({u_old.bhr, u_taken});
            u_new.target = u_taken ? u_target : u_old.target;
        end else begin
            u_new.target = u_target;
            u_new.bhr    = '1;
            for (int c = 0; c < NUM_CNT; c++) u_new.counter[c] = counter_t'(1 << (COUNTER_BITS - 1));
        end
    end

    plru_tree #(.WAYS(ASSOCIATIVITY)) u_plru_pred (
        .tree      (plru[p_idx]),
        .touch     (p_way),
        .next_tree (p_plru_next),
        .victim    ()
    );

    plru_tree #(.WAYS(ASSOCIATIVITY)) u_plru_upd (
        .tree      (plru[u_idx]),
        .touch     (u_wr_way),
        .next_tree (u_plru_next),
        .victim    (u_plru_victim)
    );

    // The update touch is written last so it wins when both ports hit the same set.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            plru[sweep_idx] <= '0;
            for (int w = 0; w < ASSOCIATIVITY; w++) meta[sweep_idx][w].valid <= 1'b0;
        end else begin
            if (pred_valid && p_hit) plru[p_idx] <= p_plru_next;
            if (u_write) begin
                plru[u_idx]            <= u_plru_next;
                meta[u_idx][u_wr_way]  <= {1'b1, u_tag};
                entry[u_idx][u_wr_way] <= u_new;
            end
        end
    end
endmodule
